// File: rtl/axi_st_patchkr_pkg.sv
// Shared types and constants for the AXI-ST half2full pattern checker run sequencer.
package axi_st_patchkr_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    CLR  = 3'd2,
    WAIT = 3'd3,
    GAP  = 3'd4,
    DONE = 3'd5
  } state_e;

  localparam logic [1:0] PASS  = 2'b11;
  localparam logic [1:0] FAIL  = 2'b10;
  localparam logic [1:0] ARMED = 2'b00;

  localparam int CLR_MAX = 8;

endpackage

// File: rtl/axi_st_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module axi_st_sat_cnt #(
  parameter int W = 16
) (
  input  logic         rdclk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count register, holds at all-ones
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/axi_st_patchkr_seq_ctrl.sv
// Run sequencer for the dual half2full pattern checker: arms the checker, requests bursts,
// collects verdicts with timeout and keeps pass/fail/timeout tallies for the CSR layer.
module axi_st_patchkr_seq_ctrl
  import axi_st_patchkr_pkg::*;
#(
  parameter int TO_W    = 20,
  parameter int ITER_W  = 16,
  parameter int GAP_CYC = 8
) (
  input  logic              rdclk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic              cfg_cont_mode,
  input  logic [ITER_W-1:0] cfg_num_iter,
  input  logic [8:0]        cfg_burst_cnt,
  input  logic [TO_W-1:0]   cfg_timeout,
  input  logic [1:0]        patchkr_out,
  input  logic              chkr_fifo_full,
  output logic              patchkr_en,
  output logic              cntuspatt_en,
  output logic              patgen_start,
  output logic [8:0]        patgen_cnt,
  output logic              busy,
  output logic              run_done,
  output logic [ITER_W-1:0] pass_cnt,
  output logic [ITER_W-1:0] fail_cnt,
  output logic [ITER_W-1:0] to_cnt,
  output logic              aborted,
  output logic [2:0]        state_dbg
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_e              r_state;
  logic                r_sh_cont;
  logic [ITER_W-1:0]   r_sh_num_iter;
  logic [TO_W-1:0]     r_sh_timeout;
  logic [8:0]          r_patgen_cnt;
  logic                r_patchkr_en;
  logic                r_cntuspatt_en;
  logic                r_patgen_start;
  logic                r_busy;
  logic                r_run_done;
  logic                r_aborted;
  logic [1:0]          r_out_q;
  logic [2:0]          r_clr_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [ITER_W-1:0]   r_iter;

  logic                w_rise;
  logic                w_start;
  logic                w_stop;
  logic                w_clr_expire;
  logic                w_to_hit;
  logic                w_gap_end;
  logic [ITER_W-1:0]   w_num_iter_eff;
  logic [ITER_W:0]     w_iter_next;
  logic                w_last_iter;
  logic                w_pass_inc;
  logic                w_fail_inc;
  logic                w_to_inc;

  assign w_rise         = patchkr_out[1] & ~r_out_q[1];
  assign w_start        = (r_state == IDLE) && cfg_start && !cfg_stop;
  assign w_stop         = (r_state != IDLE) && cfg_stop;
  assign w_clr_expire   = (patchkr_out != ARMED) && (r_clr_cnt == 3'(CLR_MAX - 1));
  assign w_to_hit       = (r_sh_timeout != '0) && (r_to_cnt == (r_sh_timeout - TO_W'(1)));
  assign w_gap_end      = (r_gap_cnt == GAP_W'(GAP_CYC - 1));
  assign w_num_iter_eff = (r_sh_num_iter == '0) ? ITER_W'(1) : r_sh_num_iter;
  assign w_iter_next    = {1'b0, r_iter} + (ITER_W + 1)'(1);
  assign w_last_iter    = (w_iter_next >= {1'b0, w_num_iter_eff});

  // Tally increments; a verdict beats a same-cycle timeout, and a stop suppresses both
  always_comb begin
    w_pass_inc = 1'b0;
    w_fail_inc = 1'b0;
    w_to_inc   = 1'b0;
    if (!cfg_stop) begin
      case (r_state)
        CLR:  w_to_inc = w_clr_expire;
        WAIT: begin
          if (w_rise) begin
            w_pass_inc = patchkr_out[0];
            w_fail_inc = ~patchkr_out[0];
          end else begin
            w_to_inc = w_to_hit;
          end
        end
        default: w_to_inc = 1'b0;
      endcase
    end else begin
      w_to_inc = 1'b0;
    end
  end

  // Sequencer FSM with registered control outputs
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_sh_cont      <= 1'b0;
      r_sh_num_iter  <= '0;
      r_sh_timeout   <= '0;
      r_patgen_cnt   <= 9'd0;
      r_patchkr_en   <= 1'b0;
      r_cntuspatt_en <= 1'b0;
      r_patgen_start <= 1'b0;
      r_busy         <= 1'b0;
      r_run_done     <= 1'b0;
      r_aborted      <= 1'b0;
      r_out_q        <= 2'b00;
      r_clr_cnt      <= 3'd0;
      r_to_cnt       <= '0;
      r_gap_cnt      <= '0;
      r_iter         <= '0;
    end else begin
      r_out_q        <= patchkr_out;
      r_patchkr_en   <= 1'b0;
      r_patgen_start <= 1'b0;
      r_run_done     <= 1'b0;
      if (w_stop) begin
        r_state        <= IDLE;
        r_aborted      <= 1'b1;
        r_cntuspatt_en <= 1'b0;
        r_run_done     <= 1'b1;
        r_busy         <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_start) begin
              r_sh_cont      <= cfg_cont_mode;
              r_sh_num_iter  <= cfg_num_iter;
              r_sh_timeout   <= cfg_timeout;
              r_patgen_cnt   <= cfg_burst_cnt;
              r_aborted      <= 1'b0;
              r_busy         <= 1'b1;
              r_iter         <= '0;
              r_patchkr_en   <= 1'b1;
              r_cntuspatt_en <= cfg_cont_mode;
              r_state        <= ARM;
            end
          end
          ARM: begin
            r_clr_cnt <= 3'd0;
            r_state   <= CLR;
          end
          CLR: begin
            // FIFO back-pressure stalls here without consuming the restart budget
            if (patchkr_out == ARMED) begin
              if (!chkr_fifo_full) begin
                r_patgen_start <= 1'b1;
                r_to_cnt       <= '0;
                r_state        <= WAIT;
              end
            end else if (w_clr_expire) begin
              r_gap_cnt <= '0;
              r_state   <= GAP;
            end else begin
              r_clr_cnt <= r_clr_cnt + 3'd1;
            end
          end
          WAIT: begin
            if (w_rise || w_to_hit) begin
              r_gap_cnt <= '0;
              r_state   <= GAP;
            end else if (r_to_cnt != {TO_W{1'b1}}) begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end
          GAP: begin
            if (!w_gap_end) begin
              r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end else if (r_sh_cont) begin
              r_clr_cnt <= 3'd0;
              r_state   <= CLR;
            end else begin
              r_iter <= w_iter_next[ITER_W-1:0];
              if (w_last_iter) begin
                r_run_done     <= 1'b1;
                r_cntuspatt_en <= 1'b0;
                r_state        <= DONE;
              end else begin
                r_patchkr_en <= 1'b1;
                r_state      <= ARM;
              end
            end
          end
          DONE: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  axi_st_sat_cnt #(.W(ITER_W)) u_pass_cnt (
    .rdclk(rdclk), .rst_n(rst_n), .i_clr(w_start), .i_inc(w_pass_inc), .o_cnt(pass_cnt)
  );

  axi_st_sat_cnt #(.W(ITER_W)) u_fail_cnt (
    .rdclk(rdclk), .rst_n(rst_n), .i_clr(w_start), .i_inc(w_fail_inc), .o_cnt(fail_cnt)
  );

  axi_st_sat_cnt #(.W(ITER_W)) u_to_cnt (
    .rdclk(rdclk), .rst_n(rst_n), .i_clr(w_start), .i_inc(w_to_inc), .o_cnt(to_cnt)
  );

  assign patchkr_en   = r_patchkr_en;
  assign cntuspatt_en = r_cntuspatt_en;
  assign patgen_start = r_patgen_start;
  assign patgen_cnt   = r_patgen_cnt;
  assign busy         = r_busy;
  assign run_done     = r_run_done;
  assign aborted      = r_aborted;
  assign state_dbg    = r_state;

endmodule

// File: tb/tb_axi_st_patchkr_seq_ctrl.sv
// Scoreboard bench for the pattern-checker run sequencer with a behavioural checker model.
module tb_axi_st_patchkr_seq_ctrl;
  import axi_st_patchkr_pkg::*;

  localparam int TO_W    = 20;
  localparam int ITER_W  = 16;
  localparam int GAP_CYC = 8;

  logic              rdclk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_start, cfg_stop, cfg_cont_mode;
  logic [ITER_W-1:0] cfg_num_iter;
  logic [8:0]        cfg_burst_cnt;
  logic [TO_W-1:0]   cfg_timeout;
  logic [1:0]        patchkr_out;
  logic              chkr_fifo_full;
  logic              patchkr_en, cntuspatt_en, patgen_start, busy, run_done, aborted;
  logic [8:0]        patgen_cnt;
  logic [ITER_W-1:0] pass_cnt, fail_cnt, to_cnt;
  logic [2:0]        state_dbg;

  axi_st_patchkr_seq_ctrl #(.TO_W(TO_W), .ITER_W(ITER_W), .GAP_CYC(GAP_CYC)) dut (
    .rdclk(rdclk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_cont_mode(cfg_cont_mode), .cfg_num_iter(cfg_num_iter), .cfg_burst_cnt(cfg_burst_cnt),
    .cfg_timeout(cfg_timeout), .patchkr_out(patchkr_out), .chkr_fifo_full(chkr_fifo_full),
    .patchkr_en(patchkr_en), .cntuspatt_en(cntuspatt_en), .patgen_start(patgen_start),
    .patgen_cnt(patgen_cnt), .busy(busy), .run_done(run_done), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt), .to_cnt(to_cnt), .aborted(aborted), .state_dbg(state_dbg)
  );

  always #5 rdclk = ~rdclk;

  int n_checks = 0;
  int n_errors = 0;

  // Checker model knobs, scoreboard and monitor statistics
  int resp_q[$];
  int exp_q[$];
  int m_lat_cfg = 40;
  int m_arm_cd = 0, m_vd_cd = 0, m_rst_cd = 0;
  logic [1:0] m_pend = 2'b00;
  int n_patgen = 0, n_pken = 0, n_done = 0, wait_cyc = 0, clr_cyc = 0, cont_viol = 0;
  bit cont_chk = 1'b0;
  int prev_pass = 0, prev_fail = 0, prev_to = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input int kind);
    int e;
    check_val("sb_nonempty", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_val("iter_kind", kind, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge rdclk);
    #3;
  endtask

  task automatic clear_stats();
    n_patgen = 0; n_pken = 0; n_done = 0; wait_cyc = 0; clr_cyc = 0; cont_viol = 0;
  endtask

  task automatic start_run(input logic cont, input int num, input logic [8:0] burst, input int tmo);
    cfg_cont_mode = cont;
    cfg_num_iter  = ITER_W'(num);
    cfg_burst_cnt = burst;
    cfg_timeout   = TO_W'(tmo);
    cfg_start     = 1'b1;
    tick(1);
    cfg_start     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int s = n_done;
    int k = 0;
    while (n_done == s && k < budget) begin
      tick(1);
      k++;
    end
    tick(1);
    check_val("run_done_pulses", n_done - s, 1);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget);
    int k = 0;
    while (state_dbg != st && k < budget) begin
      tick(1);
      k++;
    end
    check_val("reach_state", state_dbg, st);
  endtask

  task automatic wait_pass(input int n, input int budget);
    int k = 0;
    while (pass_cnt < ITER_W'(n) && k < budget) begin
      tick(1);
      k++;
    end
    check_val("reach_pass", pass_cnt, n);
  endtask

  function automatic logic [63:0] ctl_vec();
    return 64'({patchkr_en, cntuspatt_en, patgen_start, patgen_cnt, busy, run_done, aborted, state_dbg});
  endfunction

  function automatic logic [63:0] cnt_vec();
    return 64'({pass_cnt, fail_cnt, to_cnt});
  endfunction

  // Checker/generator model plus monitor, all on the falling edge
  initial begin : model
    int r;
    forever begin
      @(negedge rdclk);
      if (!rst_n) begin
        m_arm_cd = 0; m_vd_cd = 0; m_rst_cd = 0;
        prev_pass = 0; prev_fail = 0; prev_to = 0;
      end else begin
        if (patchkr_en) begin
          n_pken++;
          m_arm_cd = 4;
        end else if (m_arm_cd > 0) begin
          m_arm_cd--;
          if (m_arm_cd == 0) patchkr_out = 2'b00;
        end
        if (patgen_start) begin
          n_patgen++;
          r = (resp_q.size() > 0) ? resp_q.pop_front() : 0;
          if (r != 0) begin
            m_pend  = r[1:0];
            m_vd_cd = m_lat_cfg;
          end else if (cfg_timeout != '0) begin
            exp_q.push_back(2);
          end
        end else if (m_vd_cd > 0) begin
          m_vd_cd--;
          if (m_vd_cd == 0) begin
            patchkr_out = m_pend;
            exp_q.push_back((m_pend == 2'b11) ? 0 : 1);
            if (cntuspatt_en) m_rst_cd = 4;
          end
        end
        if (m_rst_cd > 0 && !patgen_start) begin
          m_rst_cd--;
          if (m_rst_cd == 0) patchkr_out = 2'b00;
        end
        if (state_dbg == 3'd3) wait_cyc++;
        if (state_dbg == 3'd2) clr_cyc++;
        if (run_done) n_done++;
        if (cont_chk && busy && !cntuspatt_en) cont_viol++;
        if (int'(pass_cnt) == prev_pass + 1) sb_pop(0);
        if (int'(fail_cnt) == prev_fail + 1) sb_pop(1);
        if (int'(to_cnt) == prev_to + 1) sb_pop(2);
        prev_pass = int'(pass_cnt);
        prev_fail = int'(fail_cnt);
        prev_to   = int'(to_cnt);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    cfg_start = 1'b0; cfg_stop = 1'b0; cfg_cont_mode = 1'b0;
    cfg_num_iter = '0; cfg_burst_cnt = 9'd0; cfg_timeout = '0;
    chkr_fifo_full = 1'b0;
    patchkr_out = 2'b11;
    #1;
    check_val("rst_ctl", ctl_vec(), 64'd0);
    check_val("rst_cnt", cnt_vec(), 64'd0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check_val("idle_ctl", ctl_vec(), 64'd0);

    // 1: fixed mode, three passes; config change mid-run must not leak in
    clear_stats();
    resp_q = '{3, 3, 3};
    start_run(1'b0, 3, 9'd16, 0);
    check_val("t1_busy", busy, 1);
    cfg_burst_cnt = 9'd99;
    tick(50);
    check_val("t1_patgen_cnt_held", patgen_cnt, 16);
    wait_done(2000);
    check_val("t1_pass", pass_cnt, 3);
    check_val("t1_fail", fail_cnt, 0);
    check_val("t1_patgen", n_patgen, 3);
    check_val("t1_arm_pulses", n_pken, 3);
    check_val("t1_busy_after", busy, 0);
    check_val("t1_sb_drained", exp_q.size(), 0);

    // 2: fail then pass
    clear_stats();
    resp_q = '{2, 3};
    start_run(1'b0, 2, 9'd8, 0);
    wait_done(2000);
    check_val("t2_fail", fail_cnt, 1);
    check_val("t2_pass", pass_cnt, 1);
    check_val("t2_to", to_cnt, 0);
    check_val("t2_patgen", n_patgen, 2);

    // 3: no response, timeout 100
    clear_stats();
    resp_q = '{0};
    start_run(1'b0, 1, 9'd4, 100);
    wait_done(1000);
    check_val("t3_to", to_cnt, 1);
    check_val("t3_wait_cycles", wait_cyc, 100);
    check_val("t3_pass", pass_cnt, 0);
    check_val("t3_sb_drained", exp_q.size(), 0);

    // 4: continuous mode, five passes then stop mid-WAIT
    clear_stats();
    resp_q = '{3, 3, 3, 3, 3};
    cont_chk = 1'b1;
    start_run(1'b1, 0, 9'd32, 0);
    wait_pass(5, 3000);
    wait_state(3'd3, 100);
    tick(10);
    check_val("t4_still_wait", state_dbg, 3'd3);
    cfg_stop = 1'b1;
    tick(1);
    cfg_stop = 1'b0;
    check_val("t4_stop_state", state_dbg, 3'd0);
    check_val("t4_stop_cont", cntuspatt_en, 0);
    check_val("t4_stop_done", run_done, 1);
    check_val("t4_aborted", aborted, 1);
    cont_chk = 1'b0;
    tick(2);
    check_val("t4_pass", pass_cnt, 5);
    check_val("t4_arm_pulses", n_pken, 1);
    check_val("t4_cont_level", cont_viol, 0);
    check_val("t4_patgen", n_patgen, 6);
    check_val("t4_done_pulses", n_done, 1);
    check_val("t4_busy", busy, 0);

    // stop alone in IDLE, then start+stop together: neither starts a run
    clear_stats();
    cfg_stop = 1'b1;
    tick(1);
    cfg_stop = 1'b0;
    cfg_start = 1'b1; cfg_stop = 1'b1;
    tick(1);
    cfg_start = 1'b0; cfg_stop = 1'b0;
    tick(3);
    check_val("idle_stop_busy", busy, 0);
    check_val("idle_stop_arm", n_pken, 0);
    check_val("idle_stop_done", n_done, 0);
    check_val("idle_stop_aborted", aborted, 1);

    // 5a: FIFO full stalls the burst request in CLR
    clear_stats();
    resp_q = '{3};
    chkr_fifo_full = 1'b1;
    start_run(1'b0, 1, 9'd16, 0);
    for (int k = 0; k < 100 && clr_cyc < 20; k++) tick(1);
    check_val("t5_no_start_while_full", n_patgen, 0);
    check_val("t5_in_clr", state_dbg, 3'd2);
    chkr_fifo_full = 1'b0;
    wait_done(1000);
    check_val("t5_patgen", n_patgen, 1);
    check_val("t5_pass", pass_cnt, 1);
    check_val("t5_clr_stall", clr_cyc >= 21, 1);

    // 5b: verdict lands in the timeout cycle
    clear_stats();
    resp_q = '{3};
    m_lat_cfg = 49;
    start_run(1'b0, 1, 9'd16, 50);
    wait_done(1000);
    m_lat_cfg = 40;
    check_val("t5b_pass", pass_cnt, 1);
    check_val("t5b_to", to_cnt, 0);
    check_val("t5b_wait_cycles", wait_cyc, 50);

    // 6: asynchronous reset during WAIT, then num_iter = 0 runs once
    clear_stats();
    resp_q = '{3, 0};
    start_run(1'b0, 2, 9'd16, 0);
    wait_pass(1, 1000);
    wait_state(3'd3, 100);
    tick(5);
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_ctl", ctl_vec(), 64'd0);
    check_val("t6_rst_cnt", cnt_vec(), 64'd0);
    resp_q.delete();
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    clear_stats();
    tick(5);
    check_val("t6_no_pulse", n_done + n_pken + n_patgen, 0);
    check_val("t6_idle_ctl", ctl_vec(), 64'd0);

    clear_stats();
    resp_q = '{3, 3};
    start_run(1'b0, 0, 9'd16, 0);
    wait_done(1000);
    tick(20);
    check_val("t6_iter0_patgen", n_patgen, 1);
    check_val("t6_iter0_pass", pass_cnt, 1);
    check_val("t6_iter0_busy", busy, 0);
    check_val("t6_sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
